// File: rtl/wb_regfile_commit_pkg.sv
// Shared cpu constants and types for the write-back stage.
package wb_regfile_commit_pkg;

    localparam int              REG_W    = 5;
    localparam int              XLEN     = 32;
    localparam logic [REG_W-1:0] LINK_REG = 5'd31;
    localparam logic [XLEN-1:0]  NOP      = 32'h0;

    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } fwd_t;

    // Call link address wins over load data, which wins over the ALU result.
    function automatic logic [XLEN-1:0] wb_result(
        input logic            call,
        input logic            mem_to_reg,
        input logic [XLEN-1:0] pcplus4,
        input logic [XLEN-1:0] memout,
        input logic [XLEN-1:0] aluout
    );
        return call ? pcplus4 : (mem_to_reg ? memout : aluout);
    endfunction

endpackage

// File: rtl/wb_regfile_commit_if.sv
// MEM/WB bundle, decode read ports and hazard/counter outputs of the write-back stage.
interface wb_regfile_commit_if #(
    parameter int CNT_W = 32
);
    import wb_regfile_commit_pkg::*;

    logic [XLEN-1:0]  wb_inst;
    logic [XLEN-1:0]  wb_ALUOUT;
    logic [XLEN-1:0]  wb_MEMOUT;
    logic [XLEN-1:0]  wb_pcplus4;
    logic [REG_W-1:0] wb_RegisterRd;
    logic             wb_MemtoReg;
    logic             wb_RegWrite;
    logic             wb_call;
    logic             wb_hold;
    logic [REG_W-1:0] id_rs_addr;
    logic [REG_W-1:0] id_rt_addr;
    logic [XLEN-1:0]  id_rs_data;
    logic [XLEN-1:0]  id_rt_data;
    logic             fwd_we;
    logic [REG_W-1:0] fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] write_cnt;

    modport master (
        output wb_inst, wb_ALUOUT, wb_MEMOUT, wb_pcplus4, wb_RegisterRd,
               wb_MemtoReg, wb_RegWrite, wb_call, wb_hold, id_rs_addr, id_rt_addr,
        input  id_rs_data, id_rt_data, fwd_we, fwd_rd, fwd_data, retired_cnt, write_cnt
    );

    modport slave (
        input  wb_inst, wb_ALUOUT, wb_MEMOUT, wb_pcplus4, wb_RegisterRd,
               wb_MemtoReg, wb_RegWrite, wb_call, wb_hold, id_rs_addr, id_rt_addr,
        output id_rs_data, id_rt_data, fwd_we, fwd_rd, fwd_data, retired_cnt, write_cnt
    );

endinterface

// File: rtl/wb_regfile_commit_gpr_file.sv
// 2R1W general-purpose register file: async reads, r0 hardwired to zero, async reset.
module wb_regfile_commit_gpr_file
    import wb_regfile_commit_pkg::XLEN;
#(
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_a_i,
    input  logic [AW-1:0]   raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] mem_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/wb_regfile_commit.sv
// Write-back stage: result select, GPR commit with same-cycle read bypass,
// registered forwarding info for the hazard unit, and retire/write counters.
module wb_regfile_commit
    import wb_regfile_commit_pkg::XLEN, wb_regfile_commit_pkg::REG_W,
           wb_regfile_commit_pkg::NOP, wb_regfile_commit_pkg::fwd_t,
           wb_regfile_commit_pkg::wb_result;
#(
    parameter int               NREG     = 32,
    parameter logic [REG_W-1:0] LINK_REG = wb_regfile_commit_pkg::LINK_REG,
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_regfile_commit_if.slave bus
);

    logic [XLEN-1:0]  result;
    logic [REG_W-1:0] dest;
    logic             commit;
    logic [XLEN-1:0]  rf_a, rf_b;
    logic             byp_a, byp_b;
    fwd_t             fwd_q, fwd_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] wr_q, wr_d;

    assign result = wb_result(bus.wb_call, bus.wb_MemtoReg, bus.wb_pcplus4,
                              bus.wb_MEMOUT, bus.wb_ALUOUT);
    assign dest   = bus.wb_call ? LINK_REG : bus.wb_RegisterRd;
    assign commit = (bus.wb_RegWrite | bus.wb_call) & ~bus.wb_hold & (dest != '0);

    wb_regfile_commit_gpr_file #(.NREG(NREG)) u_gpr_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (commit),
        .waddr_i  (dest),
        .wdata_i  (result),
        .raddr_a_i(bus.id_rs_addr),
        .raddr_b_i(bus.id_rt_addr),
        .rdata_a_o(rf_a),
        .rdata_b_o(rf_b)
    );

    // Bypass is gated by rst so reads are zero while reset is held; commit already excludes r0.
    assign byp_a = ~rst & commit & (bus.id_rs_addr == dest);
    assign byp_b = ~rst & commit & (bus.id_rt_addr == dest);
    assign bus.id_rs_data = byp_a ? result : rf_a;
    assign bus.id_rt_data = byp_b ? result : rf_b;

    always_comb begin
        fwd_d = fwd_q;
        ret_d = ret_q;
        wr_d  = wr_q;
        if (!bus.wb_hold) begin
            fwd_d = '{we: commit, rd: dest, data: result};
            if (bus.wb_inst != NOP) ret_d = ret_q + 1'b1;
        end
        if (commit) wr_d = wr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q <= '0;
            ret_q <= '0;
            wr_q  <= '0;
        end else begin
            fwd_q <= fwd_d;
            ret_q <= ret_d;
            wr_q  <= wr_d;
        end
    end

    assign bus.fwd_we      = fwd_q.we;
    assign bus.fwd_rd      = fwd_q.rd;
    assign bus.fwd_data    = fwd_q.data;
    assign bus.retired_cnt = ret_q;
    assign bus.write_cnt   = wr_q;

endmodule
